conv_window_addr_gen: RTL

- Generates the read-address stream for a KxK, stride-1 convolution window sweep over an image held row-major in feature-map RAM.
- Sits directly upstream of the MAC datapath's buffer-read port. Valid/ready handshake on the output.
- Raster order: window position (oy, ox), then kernel offsets (ky, kx), kx fastest.
- Built from nested stop/wrap counters. No multiplier in the address path.

---
 rtl/conv_addr_pkg.sv | 22 ++
 rtl/wrap_counter.sv | 27 ++
 rtl/conv_window_addr_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/conv_addr_pkg.sv
// Shared types, default widths and the sweep-length helper for the
// convolution window address generator.
package conv_addr_pkg;

  localparam int unsigned DefAddrBits = 16;
  localparam int unsigned DefDimBits  = 8;
  localparam int unsigned DefKBits    = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } addr_gen_state_e;

  // Number of addresses a legal sweep emits; 0 for an illegal configuration.
  function automatic int unsigned total_addrs(input int unsigned w, input int unsigned h,
                                              input int unsigned k);
    if (k == 0 || k > w || k > h) return 0;
    return (h - k + 1) * (w - k + 1) * k * k;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter over 0..max_i that wraps to 0; wrap_o flags an enabled step at max.
module wrap_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= (r_count == max_i) ? '0 : r_count + Width'(1);
    end
  end

  assign count_o = r_count;
  assign wrap_o  = en_i && (r_count == max_i);

endmodule

// File: rtl/conv_window_addr_gen.sv
// Read-address generator for a KxK stride-1 window sweep over a row-major image,
// built from chained wrap counters and an additive row-base accumulator.
module conv_window_addr_gen
  import conv_addr_pkg::*;
#(
  parameter int unsigned AddrBits = DefAddrBits,
  parameter int unsigned DimBits  = DefDimBits,
  parameter int unsigned KBits    = DefKBits
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [DimBits-1:0]  img_width_i,
  input  logic [DimBits-1:0]  img_height_i,
  input  logic [KBits-1:0]    kernel_size_i,
  input  logic [AddrBits-1:0] base_addr_i,
  output logic [AddrBits-1:0] addr_o,
  output logic                addr_valid_o,
  input  logic                addr_ready_i,
  output logic                window_last_o,
  output logic                frame_last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_err_o
);

  addr_gen_state_e r_state, w_state_next;

  logic [DimBits-1:0]  r_w, r_h;
  logic [KBits-1:0]    r_k;
  logic [AddrBits-1:0] r_base, r_win_row, r_row;
  logic                r_cfg_err;

  logic [KBits-1:0]    w_kx, w_ky, w_k_max;
  logic [DimBits-1:0]  w_ox, w_oy, w_ox_max, w_oy_max;
  logic                w_kx_wrap, w_ky_wrap, w_ox_wrap, w_oy_wrap;
  logic                w_start_ok, w_cfg_bad, w_xfer, w_win_last, w_frame_last;
  logic [AddrBits-1:0] w_w_ext;

  assign w_start_ok = (r_state == IDLE) && start_i;
  assign w_cfg_bad  = (kernel_size_i == '0) ||
                      (32'(kernel_size_i) > 32'(img_width_i)) ||
                      (32'(kernel_size_i) > 32'(img_height_i));
  assign w_xfer     = (r_state == RUN) && addr_ready_i;

  assign w_k_max  = r_k - KBits'(1);
  assign w_ox_max = r_w - DimBits'(r_k);
  assign w_oy_max = r_h - DimBits'(r_k);
  assign w_w_ext  = AddrBits'(r_w);

  // Each counter steps only when every faster counter wraps on this transfer.
  wrap_counter #(.Width(KBits)) u_kx (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(w_start_ok), .en_i(w_xfer),
    .max_i(w_k_max), .count_o(w_kx), .wrap_o(w_kx_wrap)
  );
  wrap_counter #(.Width(KBits)) u_ky (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(w_start_ok), .en_i(w_kx_wrap),
    .max_i(w_k_max), .count_o(w_ky), .wrap_o(w_ky_wrap)
  );
  wrap_counter #(.Width(DimBits)) u_ox (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(w_start_ok), .en_i(w_ky_wrap),
    .max_i(w_ox_max), .count_o(w_ox), .wrap_o(w_ox_wrap)
  );
  wrap_counter #(.Width(DimBits)) u_oy (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(w_start_ok), .en_i(w_ox_wrap),
    .max_i(w_oy_max), .count_o(w_oy), .wrap_o(w_oy_wrap)
  );

  // r_win_row = oy*W, r_row = (oy+ky)*W, both kept by addition only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_w       <= '0;
      r_h       <= '0;
      r_k       <= '0;
      r_base    <= '0;
      r_cfg_err <= 1'b0;
      r_win_row <= '0;
      r_row     <= '0;
    end else if (w_start_ok) begin
      r_w       <= img_width_i;
      r_h       <= img_height_i;
      r_k       <= kernel_size_i;
      r_base    <= base_addr_i;
      r_cfg_err <= w_cfg_bad;
      r_win_row <= '0;
      r_row     <= '0;
    end else if (w_kx_wrap) begin
      if (w_ox_wrap) begin
        r_win_row <= r_win_row + w_w_ext;
        r_row     <= r_win_row + w_w_ext;
      end else if (w_ky_wrap) begin
        r_row <= r_win_row;
      end else begin
        r_row <= r_row + w_w_ext;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_state_next = w_cfg_bad ? DONE : RUN;
      RUN:     if (w_oy_wrap) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_win_last   = (r_state == RUN) && (w_kx == w_k_max) && (w_ky == w_k_max);
  assign w_frame_last = w_win_last && (w_ox == w_ox_max) && (w_oy == w_oy_max);

  always_comb begin
    addr_o        = r_base + r_row + AddrBits'(w_ox) + AddrBits'(w_kx);
    addr_valid_o  = (r_state == RUN);
    busy_o        = (r_state == RUN);
    done_o        = (r_state == DONE);
    window_last_o = w_win_last;
    frame_last_o  = w_frame_last;
    cfg_err_o     = r_cfg_err;
  end

endmodule
